// File: rtl/pc_fetch_ctrl.sv
// PC and fetch-request sequencer: one fetch per instruction, next PC one cycle after exec_done.
// ifu_addr is held stable while ifu_req_ready is low; HALT is terminal until rst.
module pc_fetch_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
   parameter int                    CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ifu_req_valid,
   input  logic                  ifu_req_ready,
   output logic [ADDR_WIDTH-1:0] ifu_addr,
   input  logic                  exec_done,
   input  logic                  pc_sel,
   input  logic [ADDR_WIDTH-1:0] target,
   input  logic                  halt,
   input  logic [ADDR_WIDTH-1:0] trap_vec,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  exc_valid,
   output logic                  halted,
   output logic [CNT_WIDTH-1:0]  retire_cnt
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic                  valid_q;
   logic                  exc_q;
   logic                  halted_q;
   logic [CNT_WIDTH-1:0]  cnt_q;

   logic [ADDR_WIDTH-1:0] pc_seq_d;
   logic [ADDR_WIDTH-1:0] pc_tgt_d;
   logic [ADDR_WIDTH-1:0] pc_trap_d;
   logic [CNT_WIDTH-1:0]  cnt_inc_d;

   assign pc_seq_d  = pc_q + ADDR_WIDTH'(4);
   assign pc_tgt_d  = target & ~ADDR_WIDTH'(1);
   assign pc_trap_d = trap_vec & ~ADDR_WIDTH'(3);
   assign cnt_inc_d = cnt_q + CNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         exc_q    <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         exc_q <= 1'b0;
         unique case (state_q)
            S_FETCH: begin
               // valid is only raised here on the first cycle out of reset;
               // every other entry into FETCH arrives with valid already set.
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (ifu_req_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (exec_done) begin
                  if (halt) begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                     cnt_q    <= cnt_inc_d;
                  end else if (pc_sel && target[1]) begin
                     pc_q    <= pc_trap_d;
                     exc_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= S_FETCH;
                  end else begin
                     pc_q    <= pc_sel ? pc_tgt_d : pc_seq_d;
                     cnt_q   <= cnt_inc_d;
                     valid_q <= 1'b1;
                     state_q <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               valid_q <= 1'b0;
            end
            default: begin
               state_q <= S_FETCH;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ifu_req_valid = valid_q;
   assign ifu_addr      = pc_q;
   assign pc            = pc_q;
   assign exc_valid     = exc_q;
   assign halted        = halted_q;
   assign retire_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed literal checks followed by random traffic against a reference model.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid;
   logic        ifu_req_ready = 1'b0;
   logic [31:0] ifu_addr;
   logic        exec_done = 1'b0;
   logic        pc_sel = 1'b0;
   logic [31:0] target = '0;
   logic        halt = 1'b0;
   logic [31:0] trap_vec = '0;
   logic [31:0] pc;
   logic        exc_valid;
   logic        halted;
   logic [63:0] retire_cnt;

   int errors = 0;
   int checks = 0;
   bit model_on = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .exec_done(exec_done), .pc_sel(pc_sel), .target(target), .halt(halt),
      .trap_vec(trap_vec), .pc(pc), .exc_valid(exc_valid), .halted(halted),
      .retire_cnt(retire_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the core either has a fetch outstanding (not yet accepted),
   // an instruction in flight (fetched, awaiting exec_done), or is halted.
   logic [31:0] m_pc;
   logic [63:0] m_cnt;
   bit          m_valid, m_exc, m_halted, m_inflight;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = RST_PC; m_cnt = 0; m_valid = 0; m_exc = 0; m_halted = 0; m_inflight = 0;
      end else begin
         m_exc = 0;
         if (m_halted) begin
            m_valid = 0;
         end else if (!m_inflight) begin
            if (m_valid && ifu_req_ready) begin
               m_valid = 0;
               m_inflight = 1;
            end else begin
               m_valid = 1;
            end
         end else if (exec_done) begin
            m_inflight = 0;
            if (halt) begin
               m_halted = 1;
               m_cnt = m_cnt + 1;
            end else if (pc_sel && target[1]) begin
               m_pc = {trap_vec[31:2], 2'b00};
               m_exc = 1;
               m_valid = 1;
            end else begin
               m_pc = pc_sel ? {target[31:1], 1'b0} : m_pc + 32'd4;
               m_cnt = m_cnt + 1;
               m_valid = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("model valid", 64'(ifu_req_valid), 64'(m_valid));
         chk("model addr", 64'(ifu_addr), 64'(m_pc));
         chk("model pc", 64'(pc), 64'(m_pc));
         chk("model exc", 64'(exc_valid), 64'(m_exc));
         chk("model halted", 64'(halted), 64'(m_halted));
         chk("model cnt", retire_cnt, m_cnt);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic pulse_exec(input bit sel, input logic [31:0] tgt, input bit h);
      exec_done = 1; pc_sel = sel; target = tgt; halt = h;
      step();
      exec_done = 0; pc_sel = 0; halt = 0;
   endtask

   task automatic accept();
      ifu_req_ready = 1;
      step();
      ifu_req_ready = 0;
      chk("accept drops valid", 64'(ifu_req_valid), 64'd0);
   endtask

   initial begin
      rst = 1;
      step();
      step();
      model_on = 1;
      chk("rst valid", 64'(ifu_req_valid), 64'd0);
      chk("rst pc", 64'(pc), 64'(RST_PC));
      chk("rst cnt", retire_cnt, 64'd0);
      chk("rst halted", 64'(halted), 64'd0);
      chk("rst exc", 64'(exc_valid), 64'd0);

      rst = 0;
      ifu_req_ready = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp valid", 64'(ifu_req_valid), 64'd1);
         chk("bp addr", 64'(ifu_addr), 64'h8000_0000);
      end
      accept();

      pulse_exec(0, 32'h0, 0);
      chk("seq addr", 64'(ifu_addr), 64'h8000_0004);
      chk("seq valid", 64'(ifu_req_valid), 64'd1);
      accept();
      pulse_exec(1, 32'h8000_0101, 0);
      chk("jalr addr", 64'(ifu_addr), 64'h8000_0100);
      chk("cnt after 2", retire_cnt, 64'd2);
      accept();

      trap_vec = 32'h8000_1000;
      pulse_exec(1, 32'h8000_0102, 0);
      chk("trap exc", 64'(exc_valid), 64'd1);
      chk("trap addr", 64'(ifu_addr), 64'h8000_1000);
      chk("trap cnt", retire_cnt, 64'd2);
      accept();
      chk("trap exc cleared", 64'(exc_valid), 64'd0);

      pulse_exec(1, 32'hFFFF_FFFC, 0);
      chk("pre-wrap addr", 64'(ifu_addr), 64'hFFFF_FFFC);
      accept();
      pulse_exec(0, 32'h0, 0);
      chk("wrap addr", 64'(ifu_addr), 64'h0);
      chk("wrap cnt", retire_cnt, 64'd4);
      accept();

      pulse_exec(1, 32'h8000_0200, 1);
      chk("halt flag", 64'(halted), 64'd1);
      chk("halt pc", 64'(pc), 64'h0);
      chk("halt cnt", retire_cnt, 64'd5);
      ifu_req_ready = 1;
      for (int i = 0; i < 3; i++) pulse_exec(0, 32'h0, 0);
      chk("halted frozen pc", 64'(pc), 64'h0);
      chk("halted frozen cnt", retire_cnt, 64'd5);
      chk("halted no req", 64'(ifu_req_valid), 64'd0);

      rst = 1;
      step();
      rst = 0;
      chk("rerst pc", 64'(pc), 64'(RST_PC));
      chk("rerst halted", 64'(halted), 64'd0);
      chk("rerst cnt", retire_cnt, 64'd0);

      for (int c = 0; c < 4000; c++) begin
         rst           = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 249) == 0);
         ifu_req_ready = $urandom_range(0, 1) == 1;
         exec_done     = $urandom_range(0, 9) < 4;
         pc_sel        = $urandom_range(0, 1) == 1;
         halt          = $urandom_range(0, 39) == 0;
         target        = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
         trap_vec      = $urandom;
         step();
      end
      rst = 0; exec_done = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
